// File: rtl/sort_pkg.sv
// Shared types and constants for the sort controller.
// Pass/step counters are 2 bits wide.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_e;

  localparam int NUM_ELEM   = 4;
  localparam int NUM_STEPS  = 3;
  localparam int NUM_PASSES = 3;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NUM_PASSES - 1);

endpackage

// File: rtl/sort_cmp_swap.sv
// Single unsigned compare-swap cell shared by all sort steps.
// Equal operands are passed through unswapped.
module sort_cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  assign swapped = a > b;
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/sort_ctrl.sv
// Two-requester sort controller on one sequential compare-swap engine.
// Define SORT_CTRL_EARLY_EXIT_EN to stop after a pass with no swaps.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  input  logic [NUM_ELEM*W-1:0] req_data0,
  input  logic [NUM_ELEM*W-1:0] req_data1,
  output logic [1:0]          req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [NUM_ELEM*W-1:0] rsp_data,
  output logic                busy
);

  state_e                state_q;
  logic [CNT_W-1:0]      step_q;
  logic [CNT_W-1:0]      pass_q;
  logic [CNT_W-1:0]      step_nx;
  logic                  rr_q;
  logic                  id_q;
  logic                  gnt;
  logic                  last_step;
  logic                  last_pass;
  logic                  end_job;
  logic                  rsp_valid_q;
  logic                  busy_q;
  logic [NUM_ELEM*W-1:0] rsp_data_q;
  logic [NUM_ELEM*W-1:0] req_sel;
  logic [NUM_ELEM*W-1:0] swp_flat;
  logic [W-1:0]          arr_q   [NUM_ELEM];
  logic [W-1:0]          arr_swp [NUM_ELEM];
  logic [W-1:0]          cs_a;
  logic [W-1:0]          cs_b;
  logic [W-1:0]          cs_lo;
  logic [W-1:0]          cs_hi;
  logic                  cs_sw;

  assign step_nx   = step_q + 2'd1;
  assign last_step = (step_q == LAST_STEP);
  assign last_pass = (pass_q == LAST_PASS);

  // Round-robin grant; ready only in IDLE and never during reset
  always_comb begin
    gnt       = req_valid[rr_q] ? rr_q : ~rr_q;
    req_ready = '0;
    if (reset_n && state_q == IDLE) begin
      req_ready[gnt] = req_valid[gnt];
    end
    req_sel = gnt ? req_data1 : req_data0;
  end

  assign cs_a = arr_q[step_q];
  assign cs_b = arr_q[step_nx];

  sort_cmp_swap #(.W(W)) u_cs (
    .a       (cs_a),
    .b       (cs_b),
    .lo      (cs_lo),
    .hi      (cs_hi),
    .swapped (cs_sw)
  );

  // Array as it will look after this cycle's compare-swap
  always_comb begin
    arr_swp          = arr_q;
    arr_swp[step_q]  = cs_lo;
    arr_swp[step_nx] = cs_hi;
    swp_flat         = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      swp_flat[k*W +: W] = arr_swp[k];
    end
  end

`ifdef SORT_CTRL_EARLY_EXIT_EN
  logic swapped_q;
  assign end_job = last_step &&
                   (last_pass || !(swapped_q || cs_sw));
`else
  logic unused_cs_sw;
  assign unused_cs_sw = cs_sw;
  assign end_job      = last_step && last_pass;
`endif

  // Controller FSM, counters, element array and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      step_q      <= '0;
      pass_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef SORT_CTRL_EARLY_EXIT_EN
      swapped_q   <= 1'b0;
`endif
      for (int k = 0; k < NUM_ELEM; k++) begin
        arr_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_ready[gnt]) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
              arr_q[k] <= req_sel[k*W +: W];
            end
            id_q    <= gnt;
            rr_q    <= ~gnt;
            step_q  <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SORT;
`ifdef SORT_CTRL_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
          end
        end
        SORT: begin
          arr_q <= arr_swp;
          if (end_job) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= swp_flat;
          end else if (last_step) begin
            step_q <= '0;
            pass_q <= pass_q + 2'd1;
`ifdef SORT_CTRL_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
          end else begin
            step_q <= step_nx;
`ifdef SORT_CTRL_EARLY_EXIT_EN
            swapped_q <= swapped_q | cs_sw;
`endif
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule
